// File: rtl/batch_alloc_ctrl_pkg.sv
// Shared widths and types for the allocation ring and its rename/commit neighbours.
// The defaults match the standard configuration; parameterized instances derive their own widths.
package batch_alloc_ctrl_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 32;

   localparam int ID_W  = $clog2(DEF_DEPTH);
   localparam int PTR_W = ID_W + 1;
   localparam int CNT_W = $clog2(DEF_WIDTH) + 1;

   typedef logic [ID_W-1:0]  id_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/expand_one.sv
// Count-to-thermometer expansion: bit i of mask is set when i < num.
module expand_one #(
   parameter  int WIDTH = 8,
   localparam int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic [CNTW-1:0]  num,
   output logic [WIDTH-1:0] mask
);

   // NOTE: assigning a default before the loop keeps this block purely combinational (no latch).
   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = (CNTW'(i) < num);
      end
   end

endmodule

// File: rtl/batch_alloc_ctrl.sv
// Ring-buffer allocation controller: grants up to WIDTH consecutive entries per cycle at the tail
// and frees up to WIDTH entries per cycle in order from the head.
module batch_alloc_ctrl
   import batch_alloc_ctrl_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int IDW   = $clog2(DEPTH),
   localparam int PTRW  = IDW + 1,
   localparam int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      alloc_valid,
   input  logic [CNTW-1:0]           alloc_num,
   output logic                      alloc_ready,
   output logic [WIDTH-1:0]          alloc_mask,
   output logic [WIDTH-1:0][IDW-1:0] alloc_id,
   input  logic                      release_valid,
   input  logic [CNTW-1:0]           release_num,
   output logic [IDW-1:0]            head_id,
   output logic [PTRW-1:0]           free_count,
   output logic                      empty,
   output logic                      full
);

   localparam logic [PTRW-1:0] DEPTH_CNT = PTRW'(DEPTH);
   localparam logic [CNTW-1:0] WIDTH_CNT = CNTW'(WIDTH);

   logic [PTRW-1:0] head_ptr;
   logic [PTRW-1:0] tail_ptr;
   logic [PTRW-1:0] used;
   logic [PTRW-1:0] alloc_amt;
   logic [PTRW-1:0] rel_req;
   logic [PTRW-1:0] eff_rel;
   logic [PTRW-1:0] head_next;
   logic [CNTW-1:0] mask_num;
   logic            fire;

   // Readiness uses the registered free count only; entries released this cycle are not reusable yet.
   assign used        = DEPTH_CNT - free_count;
   assign alloc_ready = !flush && (alloc_num <= WIDTH_CNT) && (PTRW'(alloc_num) <= free_count);
   assign fire        = alloc_valid && alloc_ready && !rst;
   assign alloc_amt   = fire ? PTRW'(alloc_num) : '0;
   assign mask_num    = fire ? alloc_num : '0;

   assign rel_req   = release_valid ? PTRW'(release_num) : '0;
   assign eff_rel   = (rel_req > used) ? used : rel_req;
   assign head_next = head_ptr + eff_rel;

   expand_one #(.WIDTH(WIDTH)) u_expand (
      .num  (mask_num),
      .mask (alloc_mask)
   );

   always_comb begin
      alloc_id = '0;
      for (int i = 0; i < WIDTH; i++) begin
         alloc_id[i] = tail_ptr[IDW-1:0] + IDW'(i);
      end
   end

   assign head_id = head_ptr[IDW-1:0];
   assign empty   = (head_ptr == tail_ptr);
   assign full    = (head_ptr[IDW-1:0] == tail_ptr[IDW-1:0]) && (head_ptr[IDW] != tail_ptr[IDW]);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr   <= '0;
         tail_ptr   <= '0;
         free_count <= DEPTH_CNT;
      end else if (flush) begin
         // Releases in the flush cycle still retire, then the tail collapses onto the new head.
         head_ptr   <= head_next;
         tail_ptr   <= head_next;
         free_count <= DEPTH_CNT;
      end else begin
         head_ptr   <= head_next;
         tail_ptr   <= tail_ptr + alloc_amt;
         free_count <= free_count + eff_rel - alloc_amt;
      end
   end

endmodule

// File: tb/tb_batch_alloc_ctrl.sv
// Directed bench for batch_alloc_ctrl at WIDTH=8, DEPTH=16 with hand-computed expectations.
module tb_batch_alloc_ctrl;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            alloc_valid;
   logic [3:0]      alloc_num;
   logic            alloc_ready;
   logic [7:0]      alloc_mask;
   logic [7:0][3:0] alloc_id;
   logic            release_valid;
   logic [3:0]      release_num;
   logic [3:0]      head_id;
   logic [4:0]      free_count;
   logic            empty;
   logic            full;

   int tests_run    = 0;
   int tests_failed = 0;
   int over_rel_cnt = 0;

   batch_alloc_ctrl #(.WIDTH(8), .DEPTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .alloc_valid   (alloc_valid),
      .alloc_num     (alloc_num),
      .alloc_ready   (alloc_ready),
      .alloc_mask    (alloc_mask),
      .alloc_id      (alloc_id),
      .release_valid (release_valid),
      .release_num   (release_num),
      .head_id       (head_id),
      .free_count    (free_count),
      .empty         (empty),
      .full          (full)
   );

   always #5 clk = ~clk;

   // Flags any release that asks for more entries than are currently allocated.
   always @(posedge clk) begin
      if (!rst && !flush && release_valid && ({1'b0, release_num} > (5'd16 - free_count)))
         over_rel_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [3:0] an, input logic rv,
                        input logic [3:0] rn, input logic fl);
      alloc_valid   = av;
      alloc_num     = an;
      release_valid = rv;
      release_num   = rn;
      flush         = fl;
   endtask

   task automatic check_reset_view(input string tag);
      check({tag, "_free"},  32'(free_count), 32'd16);
      check({tag, "_empty"}, 32'(empty),      32'd1);
      check({tag, "_full"},  32'(full),       32'd0);
      check({tag, "_head"},  32'(head_id),    32'd0);
      check({tag, "_ready"}, 32'(alloc_ready), 32'd1);
      check({tag, "_mask"},  32'(alloc_mask), 32'd0);
      for (int i = 0; i < 8; i++) check({tag, "_id"}, 32'(alloc_id[i]), 32'(i));
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #2;
      check_reset_view("rst0");

      // Alloc 5 then 8
      @(negedge clk);
      rst = 1'b0;
      drive(1, 5, 0, 0, 0);
      #1;
      check("a5_mask", 32'(alloc_mask), 32'h1F);
      check("a5_id0",  32'(alloc_id[0]), 32'd0);
      @(negedge clk);
      check("a5_free", 32'(free_count), 32'd11);
      drive(1, 8, 0, 0, 0);
      #1;
      check("a8_mask", 32'(alloc_mask), 32'hFF);
      check("a8_id0",  32'(alloc_id[0]), 32'd5);
      @(negedge clk);
      check("a8_free", 32'(free_count), 32'd3);
      check("a8_full", 32'(full), 32'd0);

      // Request 4 with only 3 free; same-cycle release 2 does not help until next cycle
      drive(1, 4, 1, 2, 0);
      #1;
      check("short_ready", 32'(alloc_ready), 32'd0);
      check("short_mask",  32'(alloc_mask), 32'd0);
      @(negedge clk);
      check("rel2_free", 32'(free_count), 32'd5);
      check("rel2_head", 32'(head_id), 32'd2);
      drive(1, 4, 0, 0, 0);
      #1;
      check("retry_ready", 32'(alloc_ready), 32'd1);
      check("retry_mask",  32'(alloc_mask), 32'h0F);
      check("retry_id0",   32'(alloc_id[0]), 32'd13);
      @(negedge clk);
      check("retry_free", 32'(free_count), 32'd1);

      // Drain, then position the tail at id 14
      drive(0, 0, 1, 8, 0);
      @(negedge clk);
      check("drain1_free", 32'(free_count), 32'd9);
      check("drain1_head", 32'(head_id), 32'd10);
      drive(0, 0, 1, 7, 0);
      @(negedge clk);
      check("drain2_free",  32'(free_count), 32'd16);
      check("drain2_empty", 32'(empty), 32'd1);
      check("drain2_head",  32'(head_id), 32'd1);
      drive(1, 8, 0, 0, 0);
      #1;
      check("pos1_id0", 32'(alloc_id[0]), 32'd1);
      @(negedge clk);
      check("pos1_free", 32'(free_count), 32'd8);
      drive(1, 5, 0, 0, 0);
      #1;
      check("pos2_id0", 32'(alloc_id[0]), 32'd9);
      @(negedge clk);
      check("pos2_free", 32'(free_count), 32'd3);
      drive(0, 0, 1, 8, 0);
      @(negedge clk);
      check("pos3_free", 32'(free_count), 32'd11);
      check("pos3_head", 32'(head_id), 32'd9);

      // Wrap: alloc 4 from id 14
      drive(1, 4, 0, 0, 0);
      #1;
      check("wrap_id0", 32'(alloc_id[0]), 32'd14);
      check("wrap_id1", 32'(alloc_id[1]), 32'd15);
      check("wrap_id2", 32'(alloc_id[2]), 32'd0);
      check("wrap_id3", 32'(alloc_id[3]), 32'd1);
      @(negedge clk);
      check("wrap_free",  32'(free_count), 32'd7);
      check("wrap_full",  32'(full), 32'd0);
      check("wrap_empty", 32'(empty), 32'd0);
      drive(1, 7, 0, 0, 0);
      #1;
      check("fill_id0",  32'(alloc_id[0]), 32'd2);
      check("fill_mask", 32'(alloc_mask), 32'h7F);
      @(negedge clk);
      check("fill_free",  32'(free_count), 32'd0);
      check("fill_full",  32'(full), 32'd1);
      check("fill_empty", 32'(empty), 32'd0);
      drive(1, 1, 0, 0, 0);
      #1;
      check("full_ready", 32'(alloc_ready), 32'd0);
      check("full_mask",  32'(alloc_mask), 32'd0);
      drive(1, 0, 0, 0, 0);
      #1;
      check("zero_ready", 32'(alloc_ready), 32'd1);
      check("zero_mask",  32'(alloc_mask), 32'd0);
      @(negedge clk);
      check("zero_free", 32'(free_count), 32'd0);
      check("zero_full", 32'(full), 32'd1);

      // Steady alloc 3 + release 3 for 20 cycles
      drive(0, 0, 1, 8, 0);
      @(negedge clk);
      check("pre_ss_free", 32'(free_count), 32'd8);
      check("pre_ss_head", 32'(head_id), 32'd1);
      for (int k = 0; k < 20; k++) begin
         drive(1, 3, 1, 3, 0);
         #1;
         check("ss_ready", 32'(alloc_ready), 32'd1);
         check("ss_mask",  32'(alloc_mask), 32'h07);
         check("ss_id0",   32'(alloc_id[0]), 32'((9 + 3 * k) % 16));
         @(negedge clk);
         check("ss_head", 32'(head_id), 32'((1 + 3 * (k + 1)) % 16));
         check("ss_free", 32'(free_count), 32'd8);
      end

      // Flush with alloc and release both requested
      drive(1, 2, 1, 3, 1);
      #1;
      check("flush_ready", 32'(alloc_ready), 32'd0);
      check("flush_mask",  32'(alloc_mask), 32'd0);
      @(negedge clk);
      check("flush_free",  32'(free_count), 32'd16);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_head",  32'(head_id), 32'd0);
      check("flush_tail",  32'(alloc_id[0]), 32'd0);

      // Over-release of 9 with 4 allocated
      drive(1, 4, 0, 0, 0);
      @(negedge clk);
      check("or_alloc_free", 32'(free_count), 32'd12);
      drive(0, 0, 1, 9, 0);
      @(negedge clk);
      check("or_free",  32'(free_count), 32'd16);
      check("or_empty", 32'(empty), 32'd1);
      check("or_head",  32'(head_id), 32'd4);
      check("or_flag",  32'(over_rel_cnt), 32'd1);

      // Asynchronous reset pulse between clock edges
      drive(1, 5, 0, 0, 0);
      @(negedge clk);
      check("pre_rst_free", 32'(free_count), 32'd11);
      check("pre_rst_tail", 32'(alloc_id[0]), 32'd9);
      drive(0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check_reset_view("rst_mid");
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_free", 32'(free_count), 32'd16);
      check("post_rst_head", 32'(head_id), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
